shot_sequencer: RTL

//  Light-gun shot controller sequencing the draw datapath (background/duck/crosshair layers) per shot.
//  On a trigger pull: forces one all-black frame, then one white-target frame per live target,
//  and samples the gun photodiode in each frame to resolve HIT(idx) or MISS.

---
 rtl/DH_pkg.sv | 32 +++
 rtl/sync_edge.sv | 27 ++
 rtl/shot_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/DH_pkg.sv
// Shared types for the light-gun shot sequencer: draw modes, shot FSM states and
// the live-target search helper.
package DH_pkg;

  localparam int MAX_TARGETS = 4;

  typedef enum logic [1:0] {
    DRAW_NORMAL = 2'd0,
    DRAW_BLACK  = 2'd1,
    DRAW_TARGET = 2'd2
  } draw_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_BLACK,
    ST_TARGET,
    ST_COOL
  } shot_state_t;

  // Returns {found, index} of the lowest set bit of mask at position >= from.
  function automatic logic [2:0] find_live(input logic [MAX_TARGETS-1:0] mask,
                                           input logic [2:0]             from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = MAX_TARGETS - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input; EDGE_OUT=1 gives a one-cycle
// rising-edge pulse, EDGE_OUT=0 gives the synchronised level.
module sync_edge #(
  parameter bit EDGE_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  localparam int DEPTH = EDGE_OUT ? 3 : 2;

  logic [DEPTH-1:0] sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= {sh_q[DEPTH-2:0], d_i};
  end

  if (EDGE_OUT) begin : g_edge
    assign q_o = sh_q[1] & ~sh_q[2];
  end else begin : g_level
    assign q_o = sh_q[1];
  end

endmodule

// File: rtl/shot_sequencer.sv
// Light-gun shot controller: black frame, then one white frame per live target,
// resolving HIT/MISS from the photodiode. Optional macro: SHOT_CHEAT_CHECK_EN.
module shot_sequencer
  import DH_pkg::*;
#(
  parameter int N_TARGETS       = 2,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int SENSOR_MIN_CYC  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vblnk,
  input  logic                 trigger,
  input  logic                 light_sensor,
  input  logic                 gun_is_connected,
  input  logic [N_TARGETS-1:0] targets_live,
  output draw_mode_t           draw_mode,
  output logic [1:0]           target_idx,
  output logic                 busy,
  output logic                 hit,
  output logic [1:0]           hit_idx,
  output logic                 miss
);

  logic trig_ev, sens_lvl, vblnk_q, frame_end, frame_start;
  logic [3:0] run_q, run_d;
  logic seen_q, seen_d;
  shot_state_t state_q, state_d;
  draw_mode_t mode_q, mode_d;
  logic [1:0] idx_q, idx_d, hidx_q, hidx_d;
  logic busy_q, busy_d, hit_q, hit_d, miss_q, miss_d;
  logic [N_TARGETS-1:0] live_q, live_d;
  logic [7:0] cool_q, cool_d;
  logic [MAX_TARGETS-1:0] live_pad;
  logic [2:0] nxt;

  sync_edge #(.EDGE_OUT(1'b1)) u_trig_sync (
    .clk(clk), .rst_n(rst_n), .d_i(trigger), .q_o(trig_ev)
  );
  sync_edge #(.EDGE_OUT(1'b0)) u_sens_sync (
    .clk(clk), .rst_n(rst_n), .d_i(light_sensor), .q_o(sens_lvl)
  );

  assign frame_end   = vblnk & ~vblnk_q;
  assign frame_start = ~vblnk & vblnk_q;

  // Light only counts once the run reaches its threshold inside the visible area.
  always_comb begin
    run_d  = sens_lvl ? ((run_q == 4'hF) ? run_q : run_q + 4'd1) : 4'd0;
    seen_d = seen_q;
    if (frame_start) seen_d = 1'b0;
    else if ((run_q == 4'(SENSOR_MIN_CYC)) && !vblnk) seen_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    hidx_d  = hidx_q;
    live_d  = live_q;
    cool_d  = cool_q;
    nxt     = 3'b000;
    live_pad = '0;
    for (int i = 0; i < N_TARGETS; i++) live_pad[i] = live_q[i];

    if (!gun_is_connected) begin
      state_d = ST_IDLE;
      mode_d  = DRAW_NORMAL;
      idx_d   = 2'd0;
      busy_d  = 1'b0;
      hidx_d  = 2'd0;
      live_d  = '0;
      cool_d  = 8'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (trig_ev) begin
            busy_d = 1'b1;
            live_d = targets_live;
            if (targets_live != '0) begin
              state_d = ST_ARM;
            end else begin
              miss_d  = 1'b1;
              cool_d  = 8'd0;
              state_d = ST_COOL;
            end
          end
        end
        ST_ARM: begin
          if (frame_end) begin
            mode_d  = DRAW_BLACK;
            state_d = ST_BLACK;
          end
        end
        ST_BLACK: begin
          if (frame_end) begin
`ifdef SHOT_CHEAT_CHECK_EN
            if (seen_q) begin
              miss_d  = 1'b1;
              mode_d  = DRAW_NORMAL;
              cool_d  = 8'd0;
              state_d = ST_COOL;
            end else begin
              nxt     = find_live(live_pad, 3'd0);
              mode_d  = DRAW_TARGET;
              idx_d   = nxt[1:0];
              state_d = ST_TARGET;
            end
`else
            nxt     = find_live(live_pad, 3'd0);
            mode_d  = DRAW_TARGET;
            idx_d   = nxt[1:0];
            state_d = ST_TARGET;
`endif
          end
        end
        ST_TARGET: begin
          if (frame_end) begin
            nxt = find_live(live_pad, {1'b0, idx_q} + 3'd1);
            if (seen_q) begin
              hit_d   = 1'b1;
              hidx_d  = idx_q;
              mode_d  = DRAW_NORMAL;
              idx_d   = 2'd0;
              cool_d  = 8'd0;
              state_d = ST_COOL;
            end else if (nxt[2]) begin
              idx_d = nxt[1:0];
            end else begin
              miss_d  = 1'b1;
              mode_d  = DRAW_NORMAL;
              idx_d   = 2'd0;
              cool_d  = 8'd0;
              state_d = ST_COOL;
            end
          end
        end
        ST_COOL: begin
          if (frame_end) begin
            if (cool_q >= 8'(COOLDOWN_FRAMES - 1)) begin
              busy_d  = 1'b0;
              cool_d  = 8'd0;
              state_d = ST_IDLE;
            end else begin
              cool_d = cool_q + 8'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q <= 1'b0;
      run_q   <= 4'd0;
      seen_q  <= 1'b0;
      state_q <= ST_IDLE;
      mode_q  <= DRAW_NORMAL;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      hidx_q  <= 2'd0;
      live_q  <= '0;
      cool_q  <= 8'd0;
    end else begin
      vblnk_q <= vblnk;
      run_q   <= run_d;
      seen_q  <= seen_d;
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      hidx_q  <= hidx_d;
      live_q  <= live_d;
      cool_q  <= cool_d;
    end
  end

  assign draw_mode  = mode_q;
  assign target_idx = idx_q;
  assign busy       = busy_q;
  assign hit        = hit_q;
  assign hit_idx    = hidx_q;
  assign miss       = miss_q;

endmodule
